// File: rtl/bus_xfer_ctrl_pkg.sv
// Shared types and default sizing for the register-to-register bus transfer controller.
package bus_xfer_ctrl_pkg;

  localparam int unsigned DefIdxw = 3;
  localparam int unsigned DefNreg = 8;

  // Two-bit state encoding; IDLE must stay 0 so a cleared register means idle.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrive = 2'd1,
    StLatch = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/bus_xfer_ctrl_if.sv
// Request side and bus strobe side of the transfer controller, grouped as one bundle.
interface bus_xfer_ctrl_if import bus_xfer_ctrl_pkg::*; #(
  parameter int unsigned NREG = DefNreg,
  parameter int unsigned IDXW = DefIdxw
);

  logic            req;
  logic [IDXW-1:0] src;
  logic [IDXW-1:0] dst;
  logic            imm_en;
  logic [7:0]      imm_val;
  logic            busy;
  logic            ack;
  logic [NREG-1:0] oe;
  logic [NREG-1:0] latch;
  logic            drv_oe;
  logic [7:0]      drv_val;

  modport master (
    output req, src, dst, imm_en, imm_val,
    input  busy, ack, oe, latch, drv_oe, drv_val
  );

  modport slave (
    input  req, src, dst, imm_en, imm_val,
    output busy, ack, oe, latch, drv_oe, drv_val
  );

endinterface

// File: rtl/bus_xfer_ctrl_onehot_dec.sv
// Index-to-one-hot decoder with enable; all zeros when disabled.
module onehot_dec #(
  parameter int unsigned IDXW = 3,
  parameter int unsigned NREG = 8
) (
  input  logic [IDXW-1:0] idx_i,
  input  logic            en_i,
  output logic [NREG-1:0] onehot_o
);

  // Set the single selected bit only when enabled.
  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[idx_i] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Moves one byte across the shared internal bus: drive source, latch destination, acknowledge.
// Every output is a flop loaded from the next-state view, so strobes change only on clk edges.
module bus_xfer_ctrl import bus_xfer_ctrl_pkg::*; #(
  parameter int unsigned NREG = DefNreg,
  parameter int unsigned IDXW = DefIdxw
) (
  input logic               clk,
  input logic               rst,
  bus_xfer_ctrl_if.slave    bus
);

  state_e          state_q, state_d;
  logic [IDXW-1:0] src_q, src_d;
  logic [IDXW-1:0] dst_q, dst_d;
  logic            imm_en_q, imm_en_d;
  logic [7:0]      imm_val_q, imm_val_d;

  logic            src_en, latch_en;
  logic [NREG-1:0] oe_d, latch_d;
  logic            drv_oe_d, busy_d, ack_d;
  logic [7:0]      drv_val_d;

  logic [NREG-1:0] oe_q, latch_q;
  logic            drv_oe_q, busy_q, ack_q;
  logic [7:0]      drv_val_q;

  // Next state and field capture; request fields are only looked at while idle.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    imm_en_d  = imm_en_q;
    imm_val_d = imm_val_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req) begin
          src_d     = bus.src;
          dst_d     = bus.dst;
          imm_en_d  = bus.imm_en;
          imm_val_d = bus.imm_val;
          // Register copied onto itself is a no-op: skip the bus phases entirely.
          state_d   = (!bus.imm_en && (bus.src == bus.dst)) ? StDone : StDrive;
        end
      end
      StDrive: state_d = StLatch;
      StLatch: state_d = StDone;
      StDone:  state_d = StIdle;
    endcase
  end

  // Output values for the state being entered, registered below.
  always_comb begin
    src_en    = ((state_d == StDrive) || (state_d == StLatch)) && !imm_en_d;
    drv_oe_d  = ((state_d == StDrive) || (state_d == StLatch)) && imm_en_d;
    latch_en  = (state_d == StLatch);
    drv_val_d = drv_oe_d ? imm_val_d : 8'h00;
    busy_d    = (state_d != StIdle);
    ack_d     = (state_d == StDone);
  end

  onehot_dec #(
    .IDXW (IDXW),
    .NREG (NREG)
  ) u_oe_dec (
    .idx_i    (src_d),
    .en_i     (src_en),
    .onehot_o (oe_d)
  );

  onehot_dec #(
    .IDXW (IDXW),
    .NREG (NREG)
  ) u_latch_dec (
    .idx_i    (dst_d),
    .en_i     (latch_en),
    .onehot_o (latch_d)
  );

  // State, captured fields and output flops; reset clears everything including strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      src_q     <= '0;
      dst_q     <= '0;
      imm_en_q  <= 1'b0;
      imm_val_q <= 8'h00;
      oe_q      <= '0;
      latch_q   <= '0;
      drv_oe_q  <= 1'b0;
      drv_val_q <= 8'h00;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      imm_en_q  <= imm_en_d;
      imm_val_q <= imm_val_d;
      oe_q      <= oe_d;
      latch_q   <= latch_d;
      drv_oe_q  <= drv_oe_d;
      drv_val_q <= drv_val_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
    end
  end

  assign bus.oe      = oe_q;
  assign bus.latch   = latch_q;
  assign bus.drv_oe  = drv_oe_q;
  assign bus.drv_val = drv_val_q;
  assign bus.busy    = busy_q;
  assign bus.ack     = ack_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed bench for bus_xfer_ctrl with an attached 8-register file and an invariant monitor.
module tb_bus_xfer_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  bus_xfer_ctrl_if #(.NREG(8), .IDXW(3)) bus ();

  bus_xfer_ctrl #(
    .NREG (8),
    .IDXW (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Observed output tuple: {busy, ack, oe, latch, drv_oe, drv_val}
  logic [26:0] obs;
  assign obs = {bus.busy, bus.ack, bus.oe, bus.latch, bus.drv_oe, bus.drv_val};

  // Attached registers; reset preloads reg i with 8'h11*(i+1).
  logic [7:0] regs [8];
  logic [7:0] bus_val;

  always_comb begin
    bus_val = 8'h00;
    if (bus.drv_oe) bus_val = bus.drv_val;
    for (int i = 0; i < 8; i++) begin
      if (bus.oe[i]) bus_val = regs[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (rst) regs[i] <= 8'(8'h11 * (i + 1));
      else if (bus.latch[i]) regs[i] <= bus_val;
    end
  end

  // Bus invariants, checked every cycle away from the active edge.
  logic [8:0] prev_src;
  initial prev_src = '0;
  always @(negedge clk) begin
    n_cmp++;
    if ($countones({bus.oe, bus.drv_oe}) > 1) begin
      n_fail++;
      $display("FAIL inv_contention: got oe=%h drv_oe=%b want at most one enable", bus.oe,
               bus.drv_oe);
    end
    n_cmp++;
    if ($countones(bus.latch) > 1) begin
      n_fail++;
      $display("FAIL inv_latch_onehot: got latch=%h want at most one bit", bus.latch);
    end
    n_cmp++;
    if ((bus.latch != 8'h00) &&
        (({bus.oe, bus.drv_oe} == 9'h000) || ({bus.oe, bus.drv_oe} != prev_src))) begin
      n_fail++;
      $display("FAIL inv_latch_settled: got src=%h prev=%h latch=%h want held source",
               {bus.oe, bus.drv_oe}, prev_src, bus.latch);
    end
    n_cmp++;
    if (!bus.drv_oe && (bus.drv_val !== 8'h00)) begin
      n_fail++;
      $display("FAIL inv_drv_val_idle: got %h want 00", bus.drv_val);
    end
    prev_src = {bus.oe, bus.drv_oe};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic r, input logic [2:0] s, input logic [2:0] d,
                         input logic ie, input logic [7:0] iv);
    bus.req     = r;
    bus.src     = s;
    bus.dst     = d;
    bus.imm_en  = ie;
    bus.imm_val = iv;
  endtask

  task automatic test_reset();
    // req asserted alongside rst must be dropped
    rst = 1'b1;
    set_req(1'b1, 3'd1, 3'd2, 1'b0, 8'h00);
    step();
    step();
    n_cmp++;
    if (obs !== 27'h0) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h", obs, 27'h0);
    end
    rst = 1'b0;
    bus.req = 1'b0;
    step();
    n_cmp++;
    if (obs !== 27'h0) begin
      n_fail++;
      $display("FAIL reset_req_discard: got %h want %h", obs, 27'h0);
    end
  endtask

  task automatic test_reg_xfer();
    logic [26:0] exp_seq [4];
    exp_seq[0] = {1'b1, 1'b0, 8'h04, 8'h00, 1'b0, 8'h00};
    exp_seq[1] = {1'b1, 1'b0, 8'h04, 8'h20, 1'b0, 8'h00};
    exp_seq[2] = {1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00};
    exp_seq[3] = 27'h0;
    set_req(1'b1, 3'd2, 3'd5, 1'b0, 8'h00);
    step();
    bus.req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      n_cmp++;
      if (obs !== exp_seq[k]) begin
        n_fail++;
        $display("FAIL reg_xfer_c%0d: got %h want %h", k + 1, obs, exp_seq[k]);
      end
    end
    n_cmp++;
    if (regs[5] !== 8'h33) begin
      n_fail++;
      $display("FAIL reg_xfer_data: got %h want 33", regs[5]);
    end
  endtask

  task automatic test_imm();
    logic [26:0] exp_seq [4];
    logic [7:0]  val;
    for (int t = 0; t < 2; t++) begin
      val = (t == 0) ? 8'h5A : 8'hA5;
      exp_seq[0] = {1'b1, 1'b0, 8'h00, 8'h00, 1'b1, val};
      exp_seq[1] = {1'b1, 1'b0, 8'h00, 8'h02, 1'b1, val};
      exp_seq[2] = {1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00};
      exp_seq[3] = 27'h0;
      // second pass uses src field == dst: still a full bus sequence
      set_req(1'b1, (t == 0) ? 3'd0 : 3'd1, 3'd1, 1'b1, val);
      step();
      bus.req = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (k > 0) step();
        n_cmp++;
        if (obs !== exp_seq[k]) begin
          n_fail++;
          $display("FAIL imm%0d_c%0d: got %h want %h", t, k + 1, obs, exp_seq[k]);
        end
      end
      n_cmp++;
      if (regs[1] !== val) begin
        n_fail++;
        $display("FAIL imm%0d_data: got %h want %h", t, regs[1], val);
      end
    end
  endtask

  task automatic test_self();
    set_req(1'b1, 3'd3, 3'd3, 1'b0, 8'hFF);
    step();
    bus.req = 1'b0;
    n_cmp++;
    if (obs !== {1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL self_ack: got %h want %h", obs, {1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00});
    end
    step();
    n_cmp++;
    if (obs !== 27'h0) begin
      n_fail++;
      $display("FAIL self_idle: got %h want %h", obs, 27'h0);
    end
    n_cmp++;
    if (regs[3] !== 8'h44) begin
      n_fail++;
      $display("FAIL self_data: got %h want 44", regs[3]);
    end
  endtask

  task automatic test_held();
    logic [26:0] exp_seq [8];
    exp_seq[0] = {1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 8'h00};
    exp_seq[1] = {1'b1, 1'b0, 8'h01, 8'h80, 1'b0, 8'h00};
    exp_seq[2] = {1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00};
    exp_seq[3] = 27'h0;
    exp_seq[4] = {1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 8'h00};
    exp_seq[5] = {1'b1, 1'b0, 8'h10, 8'h04, 1'b0, 8'h00};
    exp_seq[6] = {1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00};
    exp_seq[7] = 27'h0;
    set_req(1'b1, 3'd0, 3'd7, 1'b0, 8'h00);
    step();
    // fields change mid-transfer with req still high; the next accept is at N+4
    set_req(1'b1, 3'd4, 3'd2, 1'b0, 8'h00);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      if (k == 4) bus.req = 1'b0;
      n_cmp++;
      if (obs !== exp_seq[k]) begin
        n_fail++;
        $display("FAIL held_c%0d: got %h want %h", k + 1, obs, exp_seq[k]);
      end
    end
    n_cmp++;
    if (regs[7] !== 8'h11) begin
      n_fail++;
      $display("FAIL held_data7: got %h want 11", regs[7]);
    end
    n_cmp++;
    if (regs[2] !== 8'h55) begin
      n_fail++;
      $display("FAIL held_data2: got %h want 55", regs[2]);
    end
  endtask

  task automatic test_back_to_back();
    logic [26:0] exp_seq [4];
    exp_seq[0] = {1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00};
    exp_seq[1] = 27'h0;
    exp_seq[2] = {1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00};
    exp_seq[3] = 27'h0;
    set_req(1'b1, 3'd5, 3'd5, 1'b0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 2) bus.req = 1'b0;
      n_cmp++;
      if (obs !== exp_seq[k]) begin
        n_fail++;
        $display("FAIL b2b_self_c%0d: got %h want %h", k + 1, obs, exp_seq[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    set_req(1'b1, 3'd1, 3'd6, 1'b0, 8'h00);
    step();
    bus.req = 1'b0;
    step();
    n_cmp++;
    if (obs !== {1'b1, 1'b0, 8'h02, 8'h40, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL rstmid_latch: got %h want %h", obs, {1'b1, 1'b0, 8'h02, 8'h40, 1'b0, 8'h00});
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if (obs !== 27'h0) begin
      n_fail++;
      $display("FAIL rstmid_abort: got %h want %h", obs, 27'h0);
    end
    step();
    n_cmp++;
    if (obs !== 27'h0) begin
      n_fail++;
      $display("FAIL rstmid_no_ack: got %h want %h", obs, 27'h0);
    end
  endtask

  task automatic test_random();
    int acks = 0;
    int cyc = 0;
    while ((acks < 1000) && (cyc < 20000)) begin
      set_req($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      step();
      cyc++;
      if (bus.ack) acks++;
    end
    bus.req = 1'b0;
    for (int k = 0; k < 6; k++) step();
    n_cmp++;
    if (acks != 1000) begin
      n_fail++;
      $display("FAIL random_acks: got %0d want 1000", acks);
    end
    n_cmp++;
    if (obs !== 27'h0) begin
      n_fail++;
      $display("FAIL random_drain: got %h want %h", obs, 27'h0);
    end
  endtask

  initial begin
    set_req(1'b0, 3'd0, 3'd0, 1'b0, 8'h00);
    test_reset();
    test_reg_xfer();
    test_imm();
    test_self();
    test_held();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
